// File: rtl/alu_multicycle.sv
// Multicycle ALU with a valid/ready handshake on both sides.
// SLL runs one bit per cycle in SHIFT; all other operations finish in one cycle.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   work, work_next, work_shl;
  logic [WIDTH-1:0]   op_result, result_next;
  logic [SHAMT_W-1:0] cnt, cnt_next, shamt;
  logic               zero_next, lt;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign work_shl = {work[WIDTH-2:0], 1'b0};
  assign lt       = $signed(SrcA) < $signed(SrcB);

  // Single-cycle results; SLL only reaches this path with a zero shift amount.
  always_comb begin
    op_result = '0;
    case (ALUControl)
      3'b000:  op_result = SrcA + SrcB;
      3'b001:  op_result = SrcA - SrcB;
      3'b010:  op_result = SrcA & SrcB;
      3'b011:  op_result = SrcA | SrcB;
      3'b100:  op_result = SrcA;
      3'b101:  op_result = {{(WIDTH-1){1'b0}}, lt};
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state;
    work_next   = work;
    cnt_next    = cnt;
    result_next = ALUResult;
    zero_next   = Zero;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (ALUControl == 3'b100 && shamt != '0) begin
            work_next  = SrcA;
            cnt_next   = shamt;
            state_next = SHIFT;
          end else begin
            result_next = op_result;
            zero_next   = (op_result == '0);
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        work_next = work_shl;
        cnt_next  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          result_next = work_shl;
          zero_next   = (work_shl == '0);
          state_next  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      cnt       <= cnt_next;
      ALUResult <= result_next;
      Zero      <= zero_next;
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHAMT_W SHALL equal log2(WIDTH).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit accepts an operation this cycle.
REQ-007 ALUControl  input  3  operation code from the ALU decoder.
REQ-008 SrcA  input  WIDTH  first operand.
REQ-009 SrcB  input  WIDTH  second operand; SrcB[SHAMT_W-1:0] is the shift amount for SLL.
REQ-010 out_valid  output  1  ALUResult/Zero valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 ALUResult  output  WIDTH  registered result.
REQ-013 Zero  output  1  registered flag, 1 when ALUResult == 0.

Function
REQ-014 The unit SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An operation SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; SrcA, SrcB and ALUControl are sampled only at that edge.
REQ-017 Codes: 000 add, 001 sub (SrcA-SrcB), 010 and, 011 or, 100 sll, 101 slt (signed, result 1 or 0 zero-extended); 110 and 111 SHALL produce result 0.
REQ-018 Add/sub SHALL be modulo 2^WIDTH; carry/borrow discarded; no overflow flag.
REQ-019 Non-shift codes, and sll with shift amount 0: IDLE -> DONE at the accepting edge; result SHALL be sampled by the consumer at the following edge (latency 1).
REQ-020 sll with shift amount N >= 1: IDLE -> SHIFT at the accepting edge, loading the working register with SrcA and a counter with N.
REQ-021 In SHIFT each edge SHALL shift the working register left by one bit (zero fill) and decrement the counter; the edge where the counter goes 1 -> 0 SHALL move to DONE (latency N+1).
REQ-022 Shift amount SHALL use only SrcB[SHAMT_W-1:0]; upper SrcB bits ignored.
REQ-023 In DONE, ALUResult and Zero SHALL hold stable until an edge with out_ready=1, which moves to IDLE.
REQ-024 No back-to-back: a new operation SHALL NOT be accepted in the edge that retires a result.
REQ-025 in_valid and operand changes while not in IDLE SHALL have no effect.
REQ-026 Zero SHALL be computed from the final result and registered together with ALUResult.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=0, counter=0, independent of clk.
REQ-028 rst asserted during SHIFT or DONE SHALL discard the operation; no result is produced after rst release.
REQ-029 The first acceptance SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-030 add SrcA=5, SrcB=7, out_ready=1 -> ALUResult=12, Zero=0, out_valid for exactly 1 cycle, latency 1.
REQ-031 sub SrcA=9, SrcB=9 -> ALUResult=0, Zero=1; slt SrcA=0xFFFFFFFF, SrcB=1 -> ALUResult=1.
REQ-032 sll SrcA=0x1, SrcB=0x24 (shamt 4) -> in_ready low 5 cycles, ALUResult=0x10 at latency 5; shamt 31 -> 0x80000000 at latency 32.
REQ-033 Result in DONE with out_ready=0 for 3 cycles, operands toggled -> ALUResult, Zero stable; retire on out_ready=1, in_ready returns next cycle.
REQ-034 rst pulsed mid-SHIFT (sll shamt 10, rst at cycle 4) -> outputs at reset values asynchronously, out_valid never asserts for that operation.
REQ-035 Code 110 with SrcA=3, SrcB=4 -> ALUResult=0, Zero=1, latency 1.
